// File: rtl/popcount_acc_pipe.sv
// Streaming popcount accumulator for BNN neurons: optional XNOR, grouped popcount,
// saturating per-frame accumulation, thresholded activation on a valid/ready output.
module popcount_acc_pipe #(
    parameter int unsigned VWIDTH  = 64,
    parameter int unsigned GROUP   = 4,
    parameter int unsigned CWIDTH  = 12,
    parameter bit          XNOR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VWIDTH-1:0] in_data,
    input  logic [VWIDTH-1:0] in_w,
    input  logic              in_last,
    input  logic [CWIDTH-1:0] in_thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] out_count,
    output logic              out_bit,
    output logic              out_sat
);

    // NG includes the partial remainder group; padding bits are zero so it counts correctly
    localparam int unsigned NG  = (VWIDTH + GROUP - 1) / GROUP;
    localparam int unsigned PW  = NG * GROUP;
    localparam int unsigned LW  = $clog2(VWIDTH + 1);
    localparam int unsigned SW  = ((CWIDTH > LW) ? CWIDTH : LW) + 1;
    localparam logic [SW:0] MAXV = {{(SW + 1 - CWIDTH){1'b0}}, {CWIDTH{1'b1}}};

    logic              adv_c;
    logic [VWIDTH-1:0] x_c;
    logic [PW-1:0]     xp_c;
    logic [NG*3-1:0]   grp_cnt_c;

    logic              a_valid;
    logic              a_last;
    logic [CWIDTH-1:0] a_thresh;
    logic [NG*3-1:0]   a_cnt;

    logic [CWIDTH-1:0] acc;
    logic              sat;

    logic [SW-1:0]     s_c;
    logic [SW:0]       t_full_c;
    logic              ovf_c;
    logic [CWIDTH-1:0] t_c;

    // Whole pipeline stalls only while a result is held unaccepted
    assign adv_c    = !(out_valid && !out_ready);
    assign in_ready = adv_c;

    assign x_c  = XNOR_EN ? ~(in_data ^ in_w) : in_data;
    assign xp_c = PW'(x_c);

    // Stage A leaf-group counts
    always_comb begin
        grp_cnt_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            for (int unsigned b = 0; b < GROUP; b++) begin
                grp_cnt_c[g*3 +: 3] = grp_cnt_c[g*3 +: 3] + 3'(xp_c[g*GROUP + b]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_last   <= 1'b0;
            a_thresh <= '0;
            a_cnt    <= '0;
        end else if (adv_c) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_cnt    <= grp_cnt_c;
                a_last   <= in_last;
                a_thresh <= in_thresh;
            end
        end
    end

    // Stage B: group sum and saturating accumulate, sized so nothing can wrap
    always_comb begin
        s_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            s_c = s_c + SW'(a_cnt[g*3 +: 3]);
        end
        t_full_c = (SW + 1)'(acc) + (SW + 1)'(s_c);
        ovf_c    = (t_full_c > MAXV);
        t_c      = ovf_c ? {CWIDTH{1'b1}} : t_full_c[CWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_bit   <= 1'b0;
            out_sat   <= 1'b0;
        end else if (adv_c) begin
            out_valid <= a_valid && a_last;
            if (a_valid) begin
                if (a_last) begin
                    out_count <= t_c;
                    out_sat   <= sat | ovf_c;
                    out_bit   <= (t_c >= a_thresh);
                    acc       <= '0;
                    sat       <= 1'b0;
                end else begin
                    acc <= t_c;
                    sat <= sat | ovf_c;
                end
            end
        end
    end

endmodule
